// File: rtl/wb_trace_buf.sv
// Writeback trace buffer: timestamps register-file writes and queues them in a
// first-word-fall-through FIFO with overflow accounting and stop-on-PC halt.
module wb_trace_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32,
  parameter int OVF_W = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       clear,
  input  logic                       wb_we,
  input  logic [4:0]                 wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  input  logic [XLEN-1:0]            wb_pc,
  input  logic                       stop_en,
  input  logic [XLEN-1:0]            stop_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CYC_W-1:0]           out_cycle,
  output logic [XLEN-1:0]            out_pc,
  output logic [4:0]                 out_rd,
  output logic [XLEN-1:0]            out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [OVF_W-1:0]           ovf_cnt,
  output logic                       halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CYC_W-1:0] mem_cycle [DEPTH];
  logic [XLEN-1:0]  mem_pc    [DEPTH];
  logic [4:0]       mem_rd    [DEPTH];
  logic [XLEN-1:0]  mem_data  [DEPTH];

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CYC_W-1:0] cycle_reg;
  logic             overflow_reg;
  logic [OVF_W-1:0] ovf_cnt_reg;
  logic             halted_reg;

  logic trace_event;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic stop_hit;

  assign trace_event = en & ~halted_reg & wb_we & (wb_rd != 5'd0);
  assign full        = (count_reg == CW'(DEPTH));
  assign pop         = (count_reg != '0) & out_ready;
  // A pop frees the slot in the same edge, so a full FIFO still accepts the push.
  assign push        = trace_event & (~full | pop);
  assign drop        = trace_event & full & ~pop;
  assign stop_hit    = trace_event & stop_en & (wb_pc == stop_pc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_cycle[i] <= '0;
        mem_pc[i]    <= '0;
        mem_rd[i]    <= '0;
        mem_data[i]  <= '0;
      end
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      cycle_reg    <= '0;
      overflow_reg <= 1'b0;
      ovf_cnt_reg  <= '0;
      halted_reg   <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      cycle_reg    <= '0;
      overflow_reg <= 1'b0;
      ovf_cnt_reg  <= '0;
      halted_reg   <= 1'b0;
    end else begin
      if (push) begin
        mem_cycle[wr_ptr_reg] <= cycle_reg;
        mem_pc[wr_ptr_reg]    <= wb_pc;
        mem_rd[wr_ptr_reg]    <= wb_rd;
        mem_data[wr_ptr_reg]  <= wb_data;
        wr_ptr_reg            <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
      if (en && !halted_reg) begin
        cycle_reg <= cycle_reg + CYC_W'(1);
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (ovf_cnt_reg != '1) begin
          ovf_cnt_reg <= ovf_cnt_reg + OVF_W'(1);
        end
      end
      if (stop_hit) begin
        halted_reg <= 1'b1;
      end
    end
  end

  assign out_valid = (count_reg != '0);
  assign out_cycle = mem_cycle[rd_ptr_reg];
  assign out_pc    = mem_pc[rd_ptr_reg];
  assign out_rd    = mem_rd[rd_ptr_reg];
  assign out_data  = mem_data[rd_ptr_reg];
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign ovf_cnt   = ovf_cnt_reg;
  assign halted    = halted_reg;

endmodule

// File: doc/wb_trace_buf.md
Name: wb_trace_buf

Overview:
Synthesizable writeback trace buffer for the pipelined RV32 core. It timestamps every architectural register-file write (cycle, PC, rd, data) and queues it in a parametrised FIFO. A handshaked port drains the queue, so the commit trace is available in hardware as well as in simulation. Adds an x0 filter, overflow accounting, a stop-on-PC halt mode and synchronous clear.

Parameters:
XLEN, 32, width of PC and write data
DEPTH, 16, FIFO entries; power of two, >= 2
CYC_W, 32, width of cycle timestamp counter
OVF_W, 16, width of saturating overflow counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
en  in  1  trace enable; gates capture and cycle counting
clear  in  1  synchronous flush of FIFO, counters and halt state
wb_we  in  1  register-file write strobe (RFWr)
wb_rd  in  5  destination register (A3)
wb_data  in  XLEN  write data (WD)
wb_pc  in  XLEN  PC of the writing instruction
stop_en  in  1  enable stop-on-PC mode
stop_pc  in  XLEN  halt trigger PC
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_cycle  out  CYC_W  head timestamp
out_pc  out  XLEN  head PC
out_rd  out  5  head rd
out_data  out  XLEN  head write data
count  out  $clog2(DEPTH)+1  entries held
overflow  out  1  sticky: at least one event dropped
ovf_cnt  out  OVF_W  dropped-event count, saturating
halted  out  1  stop PC captured; capture frozen

Behaviour:
- Reset (rstn=0, async): FIFO empty, count=0, out_valid=0, out_cycle/out_pc/out_rd/out_data=0, cycle counter=0, overflow=0, ovf_cnt=0, halted=0.
- Cycle counter: increments by 1 on each clk edge with en=1 and halted=0. Wraps modulo 2^CYC_W.
- Event: en & ~halted & wb_we & (wb_rd != 0). Writes to x0 are never recorded.
- Captured entry: {cycle counter value before that edge's increment, wb_pc, wb_rd, wb_data}. The first enabled cycle after reset is timestamp 0.
- FIFO is first-word-fall-through. out_valid = (count != 0). Out fields show the head entry combinationally from storage. When empty, out fields hold the last value and are don't-care to the consumer.
- Pop: out_valid & out_ready at the edge. No effect when empty.
- Push latency: an event at edge N is visible on out_* after edge N when the FIFO was empty (1 cycle).
- Full, push and no pop: event dropped, overflow<=1, ovf_cnt increments, saturating at 2^OVF_W-1. FIFO contents unchanged.
- Full, push and pop at the same edge: both occur; count stays DEPTH; no drop.
- Empty, push and out_ready=1 at the same edge: push only; the entry is not bypassed.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Stop mode: an event with stop_en=1 and wb_pc==stop_pc is captured normally, then halted<=1 at the same edge.
  - If that event is dropped because the FIFO is full, halted still sets.
  - While halted: no capture, cycle counter frozen, draining continues.
  - Only clear or reset releases halted.
- clear=1 (synchronous, highest priority): FIFO empty, cycle counter=0, overflow=0, ovf_cnt=0, halted=0. Any push or pop at that edge is discarded.
- en=0: no capture, counter frozen; draining continues.
- Reset asserted mid-operation discards all content immediately.

Test Plan:
- Reset, then en=1. Writes x5=0x0000000A at PC 0x00 on cycle 0 and x6=0x14 at PC 0x04 on cycle 1, out_ready=0 -> count=2; head {cycle 0, PC 0x00, rd 5, data 0xA}. Set out_ready=1 -> entries pop in order, then out_valid=0.
- wb_we=1, wb_rd=0, data 0xDEADBEEF -> no entry, count stays 0. Cycle counter still advances.
- DEPTH=16, out_ready=0, 20 consecutive writes -> count=16, overflow=1, ovf_cnt=4. Draining returns the first 16 events in order.
- FIFO full, one write with out_ready=1 on the same cycle -> count stays 16, ovf_cnt unchanged. The new event appears last.
- stop_en=1, stop_pc=0x1C. Program writes at 0x18, 0x1C, 0x20 -> 0x1C entry captured, halted=1, 0x20 not captured, out_cycle frozen. Pulse clear -> count=0, halted=0, cycle counter restarts at 0.
- Assert rstn=0 mid-stream with 5 entries queued -> outputs go to reset values without waiting for a clock edge.
